// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - opcodes, FSM encoding and defaults for the shared divider issue controller
package div_ctrl_pkg;

   localparam int TAG_W_DEF = 6;

   localparam logic [4:0] OP_DIV  = 5'b10100;
   localparam logic [4:0] OP_DIVU = 5'b10101;
   localparam logic [4:0] OP_REM  = 5'b10110;
   localparam logic [4:0] OP_REMU = 5'b10111;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_RESP  = 3'd3,
      ST_DRAIN = 3'd4
   } state_t;

   // Divide-by-zero and signed overflow have fixed architectural results
   function automatic logic is_fast_case(input logic [4:0] op, input logic [31:0] rs1,
                                         input logic [31:0] rs2);
      logic signed_op;
      signed_op = (op == OP_DIV) || (op == OP_REM);
      return (rs2 == 32'd0) ||
             (signed_op && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] fast_result(input logic [4:0] op, input logic [31:0] rs1,
                                               input logic [31:0] rs2);
      logic is_rem;
      is_rem = (op == OP_REM) || (op == OP_REMU);
      if (rs2 == 32'd0) begin
         return is_rem ? rs1 : 32'hFFFF_FFFF;
      end
      return is_rem ? 32'd0 : 32'h8000_0000;
   endfunction

endpackage

// File: rtl/div_rr_arb2.sv
// rtl/div_rr_arb2.sv - two-way round-robin arbiter, pointer moves only when a grant is taken
module div_rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   // 1 means port 1 was granted last, so port 0 is favoured out of reset
   logic last_q;
   logic last_d;

   // Grant the sole requester, or the port not served last on a tie
   always_comb begin
      gnt    = 2'b00;
      last_d = last_q;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = last_q ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
      if (advance) begin
         last_d = gnt[1];
      end
   end

   // Pointer register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - shares one iterative divider between two issue ports (DIV_FASTPATH_EN enables bypass of trivial cases)
module div_issue_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic [1:0]            req_valid,
   output logic [1:0]            req_ready,
   input  logic [1:0][4:0]       req_op_sel,
   input  logic [1:0][31:0]      req_rs1,
   input  logic [1:0][31:0]      req_rs2,
   input  logic [1:0][TAG_W-1:0] req_tag,
   output logic                  div_start,
   output logic [4:0]            div_op_sel,
   output logic [31:0]           div_rs1,
   output logic [31:0]           div_rs2,
   input  logic                  div_busy,
   input  logic                  div_done,
   input  logic [31:0]           div_result,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [31:0]           res_data,
   output logic [TAG_W-1:0]      res_tag,
   output logic                  res_port
);

   state_t           state_q, state_d;
   logic [4:0]       op_q, op_d;
   logic [31:0]      rs1_q, rs1_d;
   logic [31:0]      rs2_q, rs2_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic             port_q, port_d;
   logic [31:0]      data_q, data_d;

   logic [1:0]       gnt;
   logic             advance;
   logic             hs;
   logic             sel;

   div_rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_valid),
      .advance (advance),
      .gnt     (gnt)
   );

   // Next state, operand capture and handshake outputs
   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      rs1_d     = rs1_q;
      rs2_d     = rs2_q;
      tag_d     = tag_q;
      port_d    = port_q;
      data_d    = data_q;
      req_ready = 2'b00;
      div_start = 1'b0;
      advance   = 1'b0;
      hs        = 1'b0;
      sel       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!flush && !div_busy) begin
               req_ready = gnt;
            end
            hs  = |(req_valid & req_ready);
            sel = req_ready[1];
            if (hs) begin
               advance = 1'b1;
               op_d    = req_op_sel[sel];
               rs1_d   = req_rs1[sel];
               rs2_d   = req_rs2[sel];
               tag_d   = req_tag[sel];
               port_d  = sel;
`ifdef DIV_FASTPATH_EN
               if (is_fast_case(req_op_sel[sel], req_rs1[sel], req_rs2[sel])) begin
                  data_d  = fast_result(req_op_sel[sel], req_rs1[sel], req_rs2[sel]);
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
`else
               state_d = ST_ISSUE;
`endif
            end
         end
         ST_ISSUE: begin
            // The start pulse always goes out; a flush here just orphans the op
            div_start = 1'b1;
            state_d   = flush ? ST_DRAIN : ST_WAIT;
         end
         ST_WAIT: begin
            if (div_done) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  data_d  = div_result;
                  state_d = ST_RESP;
               end
            end else if (flush) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // Divider cannot be aborted: let it finish and drop its result
            if (div_done) begin
               state_d = ST_IDLE;
            end
         end
         ST_RESP: begin
            if (flush || res_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and operand/result registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         rs1_q   <= '0;
         rs2_q   <= '0;
         tag_q   <= '0;
         port_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         rs1_q   <= rs1_d;
         rs2_q   <= rs2_d;
         tag_q   <= tag_d;
         port_q  <= port_d;
         data_q  <= data_d;
      end
   end

   assign div_op_sel = op_q;
   assign div_rs1    = rs1_q;
   assign div_rs2    = rs2_q;
   assign res_valid  = (state_q == ST_RESP);
   assign res_data   = data_q;
   assign res_tag    = tag_q;
   assign res_port   = port_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;

   localparam int TW  = 6;
   localparam int LAT = 4;
   localparam logic [4:0] OP_DIV  = 5'b10100;
   localparam logic [4:0] OP_DIVU = 5'b10101;
   localparam logic [4:0] OP_REM  = 5'b10110;
   localparam logic [4:0] OP_REMU = 5'b10111;

   logic               clk;
   logic               rst;
   logic               flush;
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [1:0][4:0]    req_op_sel;
   logic [1:0][31:0]   req_rs1;
   logic [1:0][31:0]   req_rs2;
   logic [1:0][TW-1:0] req_tag;
   logic               div_start;
   logic [4:0]         div_op_sel;
   logic [31:0]        div_rs1;
   logic [31:0]        div_rs2;
   logic               div_busy;
   logic               div_done;
   logic [31:0]        div_result;
   logic               res_valid;
   logic               res_ready;
   logic [31:0]        res_data;
   logic [TW-1:0]      res_tag;
   logic               res_port;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   int div_cnt;
   logic [31:0] div_hold;

   div_issue_ctrl #(.TAG_W(TW)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op_sel (req_op_sel),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_tag    (req_tag),
      .div_start  (div_start),
      .div_op_sel (div_op_sel),
      .div_rs1    (div_rs1),
      .div_rs2    (div_rs2),
      .div_busy   (div_busy),
      .div_done   (div_done),
      .div_result (div_result),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .res_tag    (res_tag),
      .res_port   (res_port)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_div(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (op)
         OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         OP_REM:  return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   // Behavioural blocking divider: busy for LAT cycles after start, then a one-cycle done
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         div_busy   <= 1'b0;
         div_done   <= 1'b0;
         div_result <= '0;
         div_cnt    <= 0;
         div_hold   <= '0;
      end else begin
         div_done <= 1'b0;
         if (div_start) begin
            div_busy <= 1'b1;
            div_cnt  <= LAT;
            div_hold <= ref_div(div_op_sel, div_rs1, div_rs2);
         end else if (div_busy) begin
            if (div_cnt == 1) begin
               div_busy   <= 1'b0;
               div_done   <= 1'b1;
               div_result <= div_hold;
            end
            div_cnt <= div_cnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (div_start) start_cnt <= start_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input string tag, input int p, input logic [4:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
      logic ok;
      ok = 1'b0;
      req_op_sel[p] = op;
      req_rs1[p]    = a;
      req_rs2[p]    = b;
      req_tag[p]    = t;
      req_valid[p]  = 1'b1;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1;
         ok = req_ready[p];
         @(posedge clk);
         #1;
      end
      req_valid[p] = 1'b0;
      check({tag, "_handshake"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_res(input string tag, input logic [31:0] d, input logic [TW-1:0] t,
                           input logic p);
      int i;
      i = 0;
      while (!res_valid && i < 60) begin
         @(posedge clk);
         #1;
         i++;
      end
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_data"},  res_data, d);
      check({tag, "_tag"},   32'(res_tag), 32'(t));
      check({tag, "_port"},  32'(res_port), 32'(p));
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int s0;
      logic seen;
      rst        = 1'b1;
      flush      = 1'b0;
      req_valid  = '0;
      req_op_sel = '0;
      req_rs1    = '0;
      req_rs2    = '0;
      req_tag    = '0;
      res_ready  = 1'b0;

      // Reset state
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_div_start", 32'(div_start), 32'd0);
      check("rst_div_op",    32'(div_op_sel), 32'd0);
      check("rst_div_rs1",   div_rs1, 32'd0);
      check("rst_res_data",  res_data, 32'd0);
      check("rst_res_tag",   32'(res_tag), 32'd0);
      reset_dut();

      // 1: single DIV 10/3
      res_ready = 1'b1;
      s0 = start_cnt;
      issue("t1", 0, OP_DIV, 32'd10, 32'd3, 6'd5);
      check("t1_start_pulse", 32'(div_start), 32'd1);
      wait_res("t1", 32'd3, 6'd5, 1'b0);
      check("t1_start_count", 32'(start_cnt - s0), 32'd1);
      @(posedge clk);
      #1;
      check("t1_idle", 32'(res_valid), 32'd0);

      // 2: round robin after a fresh reset
      reset_dut();
      res_ready     = 1'b1;
      req_op_sel[0] = OP_DIVU; req_rs1[0] = 32'hFFFF_FFF6; req_rs2[0] = 32'd2; req_tag[0] = 6'd2;
      req_op_sel[1] = OP_REM;  req_rs1[1] = 32'hFFFF_FFF6; req_rs2[1] = 32'd3; req_tag[1] = 6'd9;
      req_valid     = 2'b11;
      #1;
      check("t2_rr_first", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_op_sel[0] = OP_DIVU; req_rs1[0] = 32'd100; req_rs2[0] = 32'd7; req_tag[0] = 6'd3;
      check("t2_busy_ready", 32'(req_ready), 32'd0);
      wait_res("t2a", 32'h7FFF_FFFB, 6'd2, 1'b0);
      @(posedge clk);
      #1;
      check("t2_rr_second", 32'(req_ready), 32'd2);
      @(posedge clk);
      #1;
      req_valid[1] = 1'b0;
      wait_res("t2b", 32'hFFFF_FFFF, 6'd9, 1'b1);
      @(posedge clk);
      #1;
      check("t2_rr_third", 32'(req_ready), 32'd1);
      @(posedge clk);
      #1;
      req_valid[0] = 1'b0;
      wait_res("t2c", 32'd14, 6'd3, 1'b0);
      @(posedge clk);
      #1;

      // 3: backpressure holds the result stable and blocks new requests
      res_ready = 1'b0;
      issue("t3", 0, OP_DIVU, 32'd50, 32'd5, 6'd7);
      wait_res("t3", 32'd10, 6'd7, 1'b0);
      req_op_sel[1] = OP_DIVU; req_rs1[1] = 32'd1; req_rs2[1] = 32'd1; req_tag[1] = 6'd1;
      req_valid[1]  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("t3_hold_valid", 32'(res_valid), 32'd1);
         check("t3_hold_data",  res_data, 32'd10);
         check("t3_hold_tag",   32'(res_tag), 32'd7);
         check("t3_no_ready",   32'(req_ready), 32'd0);
      end
      req_valid[1] = 1'b0;
      res_ready    = 1'b1;
      @(posedge clk);
      #1;
      check("t3_released", 32'(res_valid), 32'd0);

      // 4: flush while waiting drains the divider without a result
      issue("t4a", 0, OP_DIV, 32'd7, 32'd7, 6'd1);
      @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      seen  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         if (res_valid) seen = 1'b1;
      end
      check("t4_drain_no_res", 32'(seen), 32'd0);
      issue("t4b", 1, OP_DIV, 32'd20, 32'd4, 6'd11);
      wait_res("t4b", 32'd5, 6'd11, 1'b1);
      @(posedge clk);
      #1;

      // 5: flush in RESP beats res_ready
      res_ready = 1'b0;
      issue("t5", 0, OP_DIVU, 32'd9, 32'd2, 6'd4);
      wait_res("t5", 32'd4, 6'd4, 1'b0);
      flush     = 1'b1;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check("t5_dropped", 32'(res_valid), 32'd0);
      req_valid[0] = 1'b1;
      #1;
      check("t5_idle_ready", 32'(req_ready), 32'd1);
      req_valid[0] = 1'b0;
      #1;

      // 6: divide by zero and signed overflow
      s0 = start_cnt;
      issue("t6a", 0, OP_DIV, 32'd100, 32'd0, 6'd12);
`ifdef DIV_FASTPATH_EN
      check("t6a_fast_valid", 32'(res_valid), 32'd1);
      check("t6a_fast_data",  res_data, 32'hFFFF_FFFF);
      check("t6a_no_start",   32'(start_cnt - s0), 32'd0);
`else
      wait_res("t6a", 32'hFFFF_FFFF, 6'd12, 1'b0);
      check("t6a_start", 32'(start_cnt - s0), 32'd1);
`endif
      @(posedge clk);
      #1;
      s0 = start_cnt;
      issue("t6b", 1, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 6'd13);
`ifdef DIV_FASTPATH_EN
      check("t6b_fast_valid", 32'(res_valid), 32'd1);
      check("t6b_fast_data",  res_data, 32'h8000_0000);
      check("t6b_no_start",   32'(start_cnt - s0), 32'd0);
`else
      wait_res("t6b", 32'h8000_0000, 6'd13, 1'b1);
      check("t6b_start", 32'(start_cnt - s0), 32'd1);
`endif
      @(posedge clk);
      #1;
      check("t6_idle", 32'(res_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
